// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, types and bit-vector helpers for the keypad scanner.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int NKEYS = ROWS * COLS;

    typedef logic [3:0] key_code_t;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_EVAL = 1'b1
    } scan_state_t;

    typedef struct packed {
        key_code_t code;
        logic      press;
    } key_evt_t;

    // Number of keys set in a 16-key vector.
    function automatic logic [4:0] count_set(input logic [NKEYS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NKEYS; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set key; only meaningful when exactly one bit is set.
    function automatic key_code_t lowest_set(input logic [NKEYS-1:0] v);
        key_code_t idx;
        idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = key_code_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: small valid/ready event FIFO. A push into a full FIFO is
// dropped (reported on o_drop) unless a pop frees a slot in the same cycle.
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  key_evt_t i_data,
    input  logic     i_pop,
    output logic     o_valid,
    output key_evt_t o_data,
    output logic     o_drop
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    key_evt_t      r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_drop    = i_push && w_full && !w_do_pop;

    // Head is forced to zero when empty so the outputs read 0 during reset.
    assign o_valid = !w_empty;
    assign o_data  = w_empty ? key_evt_t'('0) : r_mem[r_rd_ptr[AW-1:0]];

    // Storage: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with snapshot debouncing,
// multi-key lockout and an event FIFO.
// Optional feature: define KEYPAD_RELEASE_EVT_EN to also emit release events.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DWELL_CYC      = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [3:0] key_code,
    output logic       key_press,
    output logic       overflow,
    input  logic       overflow_clr
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_SCANS);

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [COLS-1:0]   r_col;
    logic [DW-1:0]     r_dwell;
    logic [NKEYS-1:0]  r_snap;
    logic [NKEYS-1:0]  r_prev;
    logic [NKEYS-1:0]  r_stable;
    logic [MW-1:0]     r_match;
    logic              r_overflow;

    logic              w_dwell_end;
    logic              w_eval;
    logic              w_same;
    logic [MW-1:0]     w_match_nxt;
    logic              w_stable_upd;
    logic [4:0]        w_cnt_old;
    logic [4:0]        w_cnt_new;
    logic              w_push;
    key_evt_t          w_evt;
    key_evt_t          w_head;
    logic              w_drop;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave SCAN after the last dwell cycle of the last column; EVAL lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_end = 1'b0;
        w_eval      = 1'b0;
        case (r_state)
            ST_SCAN: begin
                w_dwell_end = (r_dwell == DWELL_LAST);
                if (w_dwell_end && r_col[COLS-1]) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_eval      = 1'b1;
                w_state_nxt = ST_SCAN;
            end
            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    // Column drive and dwell counter; the drive is blank during EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= 4'b0001;
            r_dwell <= '0;
        end else if (w_eval) begin
            r_col   <= 4'b0001;
            r_dwell <= '0;
        end else if (w_dwell_end) begin
            r_dwell <= '0;
            r_col   <= r_col[COLS-1] ? 4'b0000 : {r_col[COLS-2:0], 1'b0};
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    // Capture the row lines into the snapshot column on the last dwell cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (w_dwell_end) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_col[c]) begin
                    for (int r = 0; r < ROWS; r++) begin
                        r_snap[COLS*r + c] <= row[r];
                    end
                end
            end
        end
    end

    assign w_same       = (r_snap == r_prev);
    assign w_match_nxt  = !w_same ? MW'(1) :
                          (r_match == MATCH_MAX) ? r_match : (r_match + MW'(1));
    assign w_stable_upd = w_eval && (w_match_nxt == MATCH_MAX);
    assign w_cnt_old    = count_set(r_stable);
    assign w_cnt_new    = count_set(r_snap);

    // Event generation: only clean zero<->single-key transitions of the stable vector.
    always_comb begin
        w_push = 1'b0;
        w_evt  = '0;
        if (w_stable_upd) begin
            if ((w_cnt_old == 5'd0) && (w_cnt_new == 5'd1)) begin
                w_push     = 1'b1;
                w_evt.code  = lowest_set(r_snap);
                w_evt.press = 1'b1;
            end
`ifdef KEYPAD_RELEASE_EVT_EN
            else if ((w_cnt_old == 5'd1) && (w_cnt_new == 5'd0)) begin
                w_push     = 1'b1;
                w_evt.code  = lowest_set(r_stable);
                w_evt.press = 1'b0;
            end
`endif
        end
    end

    // Debounce bookkeeping, updated once per scan in EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= '0;
            r_match  <= '0;
            r_stable <= '0;
        end else if (w_eval) begin
            r_match <= w_match_nxt;
            if (!w_same) begin
                r_prev <= r_snap;
            end
            if (w_stable_upd) begin
                r_stable <= r_snap;
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    keypad_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (key_ready),
        .o_valid (key_valid),
        .o_data  (w_head),
        .o_drop  (w_drop)
    );

    assign col       = r_col;
    assign key_code  = w_head.code;
    assign key_press = w_head.press;
    assign overflow  = r_overflow;

endmodule
